adder16_result_checker: RTL and testbench
=========================================

Name: adder16_result_checker

Overview:
- Consumer-side companion to the 16-bit registered adder: observes the operands driven into the adder and the sum it returns.
- Predicts each expected sum, aligns the prediction to the adder's output latency, and compares it against the adder output.
- Counts passes and failures, captures the first failing transaction, and reports completion after a programmed number of checks.
- Sits beside the adder under test; lets directed or random operand streams self-check in hardware, not only in the bench.

Parameters:
- DATA_W, 16, operand width; sum width is DATA_W+1 (carry-out in MSB).
- LATENCY, 1, cycles from operands sampled by the adder to C valid; legal range 1..8.
- CNT_W, 16, width of the pass/fail counters and of num_checks.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- start  in  1  single-cycle pulse; begins a check run.
- num_checks  in  CNT_W  comparisons per run; sampled on start; 0 treated as 1.
- in_valid  in  1  A/B carry a new transaction this cycle.
- A  in  DATA_W  operand A as driven to the adder.
- B  in  DATA_W  operand B as driven to the adder.
- C  in  DATA_W+1  adder result.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass_cnt  out  CNT_W  matching comparisons.
- fail_cnt  out  CNT_W  mismatching comparisons.
- err  out  1  sticky; set on first mismatch of a run.
- fail_a  out  DATA_W  operand A of the first failing transaction.
- fail_b  out  DATA_W  operand B of the first failing transaction.
- fail_c  out  DATA_W+1  observed C of the first failing transaction.

Interface: one clock; reset is synchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0.
  - Prediction pipeline valid bits are cleared.
  - Applies mid-run too: in-flight predictions are discarded and no partial results are kept.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> DONE when the total of pass_cnt plus fail_cnt reaches the latched num_checks.
  - DONE -> RUN on start.
  - start while in RUN is ignored.
- Entering RUN:
  - Clears pass_cnt, fail_cnt, err, fail_a, fail_b, fail_c and the pipeline valid bits.
  - Latches num_checks.
- Prediction: exp = zero-extended A + zero-extended B, full DATA_W+1 bits, so there is no overflow loss.
- Pipeline:
  - A LATENCY-deep shift register holds {valid, A, B, exp} and advances every cycle.
  - Stage 0 loads only when in_valid=1 and state=RUN; otherwise a bubble (valid=0) enters.
- Compare cycle: a transaction sampled at edge N is compared with C at edge N+LATENCY.
- Counting:
  - Compare only when the last stage is valid and state=RUN.
  - C==exp: pass_cnt increments. Otherwise fail_cnt increments.
  - Both counters saturate at all-ones.
- First failure: on the first mismatch of a run (err==0), set err and capture fail_a/fail_b/fail_c in that cycle. Later mismatches do not overwrite them.
- Run end:
  - Completion is checked with the post-update count. The cycle after the final compare, state=DONE and done=1.
  - Predictions still in flight after DONE are drained and not counted.
  - in_valid in IDLE or DONE is ignored.
- Simultaneous events:
  - start in the same cycle as a final compare in RUN: the compare is counted, start is ignored.
  - start in DONE: any pipeline contents are flushed.

Optional Feature:
- Macro CHK_HALT_ON_FAIL_EN.
- Defined: the first mismatch moves RUN -> DONE on the next edge. fail_cnt stays at 1 and pass_cnt is frozen.
- Undefined: the run continues through failures until num_checks comparisons are complete.

Test Plan:
- Reset, then start with num_checks=4, LATENCY=1. Drive (A,B) = (1,2),(16'hFFFF,1),(16'h8000,16'h8000),(0,0) with a correct adder -> pass_cnt=4, fail_cnt=0, err=0, done=1 one cycle after the 4th compare.
- Same run with C forced to 17'h00000 on the 2nd transaction -> fail_cnt=1, pass_cnt=3, err=1, fail_a=16'hFFFF, fail_b=16'h0001, fail_c=17'h00000.
- in_valid gaps: 3 transactions spaced by 2 idle cycles, num_checks=3 -> done only after the 3rd compare; bubbles are never counted.
- Assert rst_n=0 for one cycle in the middle of a 10-check run after 5 compares -> all outputs 0, busy=0 on the next cycle; a new start yields a clean run.
- Assert start from DONE with 2 predictions still in flight -> counters clear, and the stale predictions are not compared.
- With CHK_HALT_ON_FAIL_EN defined, num_checks=8, mismatch injected on the 3rd transaction -> done=1 the next cycle, pass_cnt=2, fail_cnt=1.

Source files
------------

// File: rtl/adder16_result_checker.sv
// ---------------------------------------------------------------------------
// adder16_result_checker
//
// Sits beside a registered adder and checks it. For every operand pair
// driven into the adder it predicts the full-width sum, delays that
// prediction by the adder's output latency, and compares it with the adder
// result. It counts passes and failures, captures the first failing
// transaction of a run, and signals completion once the programmed number
// of comparisons has been made.
//
// Parameters
//   DATA_W  : operand width; results are DATA_W+1 bits (carry-out in MSB)
//   LATENCY : adder latency in cycles, 1..8
//   CNT_W   : width of pass_cnt, fail_cnt and num_checks
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   start      : one-cycle pulse, starts a run from IDLE or DONE
//   num_checks : comparisons per run, sampled on start (0 acts as 1)
//   in_valid   : A/B hold a new transaction this cycle
//   A, B       : operands as driven to the adder
//   C          : adder result
//   busy       : high while in RUN
//   done       : high while in DONE
//   pass_cnt   : matching comparisons (saturating)
//   fail_cnt   : mismatching comparisons (saturating)
//   err        : sticky, set on the first mismatch of a run
//   fail_a/b/c : operands and observed result of the first failing compare
//
// Handshake: a transaction is accepted on any rising edge where in_valid=1
// and the checker is in RUN; there is no back-pressure, the checker always
// accepts.
//
// Build option
//   CHK_HALT_ON_FAIL_EN : when defined, the first mismatch ends the run
//                         (RUN -> DONE on the next edge).
// ---------------------------------------------------------------------------
module adder16_result_checker #(
  parameter int DATA_W  = 16,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_checks,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W:0]   C,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err,
  output logic [DATA_W-1:0] fail_a,
  output logic [DATA_W-1:0] fail_b,
  output logic [DATA_W:0]   fail_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Prediction pipeline: stage LATENCY-1 lines up with the adder output.
  logic              pipe_v [LATENCY];
  logic [DATA_W-1:0] pipe_a [LATENCY];
  logic [DATA_W-1:0] pipe_b [LATENCY];
  logic [DATA_W:0]   pipe_e [LATENCY];

  logic [CNT_W-1:0]  num_lat;
  logic              cmp_en;
  logic              cmp_match;
  logic              run_enter;
  logic              last_cmp;
  logic [CNT_W-1:0]  pass_next;
  logic [CNT_W-1:0]  fail_next;
  logic [CNT_W:0]    total_next;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Compare / count / next-state logic
  always_comb begin
    cmp_en     = (state == S_RUN) && pipe_v[LATENCY-1];
    cmp_match  = (C == pipe_e[LATENCY-1]);
    pass_next  = pass_cnt;
    fail_next  = fail_cnt;
    state_next = state;
    run_enter  = 1'b0;

    if (cmp_en) begin
      if (cmp_match) begin
        if (pass_cnt != '1) pass_next = pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != '1) fail_next = fail_cnt + CNT_W'(1);
      end
    end

    // Completion uses the counts after this cycle's update; one extra bit
    // keeps the sum exact even when both counters are near saturation.
    total_next = {1'b0, pass_next} + {1'b0, fail_next};
    last_cmp   = cmp_en && (total_next >= {1'b0, num_lat});

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          run_enter  = 1'b1;
        end
      end
      S_RUN: begin
        if (last_cmp) begin
          state_next = S_DONE;
        end
`ifdef CHK_HALT_ON_FAIL_EN
        else if (cmp_en && !cmp_match) begin
          state_next = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          run_enter  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Counters, first-failure capture and prediction pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_c   <= '0;
      num_lat  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
        pipe_e[i] <= '0;
      end
    end else if (run_enter) begin
      // New run: clear results and drop anything still in flight.
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_c   <= '0;
      num_lat  <= (num_checks == '0) ? CNT_W'(1) : num_checks;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
      end
    end else begin
      pass_cnt <= pass_next;
      fail_cnt <= fail_next;
      if (cmp_en && !cmp_match && !err) begin
        err    <= 1'b1;
        fail_a <= pipe_a[LATENCY-1];
        fail_b <= pipe_b[LATENCY-1];
        fail_c <= C;
      end
      // Outside RUN only bubbles enter, so the pipe drains on its own.
      pipe_v[0] <= in_valid && (state == S_RUN);
      pipe_a[0] <= A;
      pipe_b[0] <= B;
      pipe_e[0] <= {1'b0, A} + {1'b0, B};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
    end
  end

endmodule

// File: tb/tb_adder16_result_checker.sv
// ---------------------------------------------------------------------------
// Testbench for adder16_result_checker. Two checkers watch a modelled
// registered adder: one with LATENCY=1 (main scenarios) and one with
// LATENCY=3 (in-flight predictions across a restart from DONE).
// ---------------------------------------------------------------------------
module tb_adder16_result_checker;

`ifdef CHK_HALT_ON_FAIL_EN
  localparam int HALT = 1;
`else
  localparam int HALT = 0;
`endif

  // clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] num_checks = '0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        corrupt = 1'b0;

  // adder model: registered sum, with a 3-cycle copy for the second checker
  logic [16:0] add_q1 = '0, add_q2 = '0, add_q3 = '0;
  logic [16:0] c1, c3;
  always @(posedge clk) begin
    add_q1 <= {1'b0, a} + {1'b0, b};
    add_q2 <= add_q1;
    add_q3 <= add_q2;
  end
  assign c1 = corrupt ? 17'h00000 : add_q1;
  assign c3 = add_q3;

  logic        busy, done, err;
  logic [15:0] pass_cnt, fail_cnt, fail_a, fail_b;
  logic [16:0] fail_c;
  logic        busy3, done3, err3;
  logic [15:0] pass3, fail3, fail_a3, fail_b3;
  logic [16:0] fail_c3;

  adder16_result_checker #(.DATA_W(16), .LATENCY(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_checks(num_checks),
    .in_valid(in_valid), .A(a), .B(b), .C(c1),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err(err), .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c)
  );

  adder16_result_checker #(.DATA_W(16), .LATENCY(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_checks(num_checks),
    .in_valid(in_valid), .A(a), .B(b), .C(c3),
    .busy(busy3), .done(done3), .pass_cnt(pass3), .fail_cnt(fail3),
    .err(err3), .fail_a(fail_a3), .fail_b(fail_b3), .fail_c(fail_c3)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] va [8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0000,
                          16'h0003, 16'h0010, 16'h1234, 16'hFFFF};
  logic [15:0] vb [8] = '{16'h0002, 16'h0001, 16'h8000, 16'h0000,
                          16'h0004, 16'h0020, 16'h1111, 16'hFFFF};

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start = 1'b1; num_checks = n;
    tick();
    start = 1'b0;
  endtask

  // start, then four back-to-back transactions; C is zeroed for transaction
  // index bad (-1 for none). Returns after the 4th operand edge.
  task automatic run4_stim(input int bad);
    pulse_start(16'd4);
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1; corrupt = (i == bad + 1);
      tick();
    end
    in_valid = 1'b0; corrupt = (bad == 3);
  endtask

  // scenario tasks
  task automatic test_reset();
    do_reset();
    rst_n = 1'b0; tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
    n_checks++; if (err !== 1'b0 || fail_c !== 17'd0) begin n_errors++; $display("FAIL reset_err got=%0b/%h exp=0/0", err, fail_c); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    run4_stim(-1);
    n_checks++; if (pass_cnt !== 16'd3 || done !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL basic_before_end pass=%0d done=%0b busy=%0b exp 3/0/1", pass_cnt, done, busy); end
    tick();
    n_checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin n_errors++; $display("FAIL basic_cnt got=%0d/%0d exp=4/0", pass_cnt, fail_cnt); end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL basic_done done=%0b busy=%0b err=%0b exp 1/0/0", done, busy, err); end
    tick();
    n_checks++; if (pass_cnt !== 16'd4 || done !== 1'b1) begin n_errors++; $display("FAIL basic_hold pass=%0d done=%0b exp 4/1", pass_cnt, done); end
  endtask

  task automatic test_fail();
    logic [15:0] exp_pass;
    exp_pass = (HALT != 0) ? 16'd1 : 16'd3;
    do_reset();
    run4_stim(1);
    tick();
    corrupt = 1'b0;
    n_checks++; if (pass_cnt !== exp_pass || fail_cnt !== 16'd1) begin n_errors++; $display("FAIL fail_cnt got=%0d/%0d exp=%0d/1", pass_cnt, fail_cnt, exp_pass); end
    n_checks++; if (err !== 1'b1 || done !== 1'b1) begin n_errors++; $display("FAIL fail_err err=%0b done=%0b exp 1/1", err, done); end
    n_checks++; if (fail_a !== 16'hFFFF || fail_b !== 16'h0001) begin n_errors++; $display("FAIL fail_ops got=%h/%h exp=ffff/0001", fail_a, fail_b); end
    n_checks++; if (fail_c !== 17'h00000) begin n_errors++; $display("FAIL fail_c got=%h exp=00000", fail_c); end
  endtask

  task automatic test_gaps();
    do_reset();
    pulse_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      a = va[i + 4]; b = vb[i + 4]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++; if (pass_cnt !== 16'(i + 1) || done !== (i == 2)) begin n_errors++; $display("FAIL gaps_cmp%0d pass=%0d done=%0b exp %0d/%0b", i, pass_cnt, done, i + 1, (i == 2)); end
      tick();
      n_checks++; if (pass_cnt !== 16'(i + 1) || fail_cnt !== 16'd0) begin n_errors++; $display("FAIL gaps_bubble%0d got=%0d/%0d exp=%0d/0", i, pass_cnt, fail_cnt, i + 1); end
    end
  endtask

  task automatic test_zero_checks();
    do_reset();
    pulse_start(16'd0);
    a = 16'h0005; b = 16'h0006; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (pass_cnt !== 16'd1 || done !== 1'b1) begin n_errors++; $display("FAIL zero_run pass=%0d done=%0b exp 1/1", pass_cnt, done); end
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    n_checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin n_errors++; $display("FAIL done_ignores_valid got=%0d/%0d exp=1/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] exp_pass;
    exp_pass = (HALT != 0) ? 16'd1 : 16'd4;
    do_reset();
    pulse_start(16'd10);
    for (int i = 0; i < 6; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1; corrupt = (i == 2);
      tick();
    end
    n_checks++; if (pass_cnt !== exp_pass || err !== 1'b1) begin n_errors++; $display("FAIL midrst_pre pass=%0d err=%0b exp %0d/1", pass_cnt, err, exp_pass); end
    rst_n = 1'b0; in_valid = 1'b0; corrupt = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL midrst_state busy=%0b done=%0b err=%0b exp 0/0/0", busy, done, err); end
    n_checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_errors++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", pass_cnt, fail_cnt); end
    n_checks++; if (fail_a !== 16'd0 || fail_b !== 16'd0 || fail_c !== 17'd0) begin n_errors++; $display("FAIL midrst_capture got=%h/%h/%h exp=0/0/0", fail_a, fail_b, fail_c); end
    rst_n = 1'b1;
    run4_stim(-1);
    tick();
    n_checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0 || done !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL midrst_rerun pass=%0d fail=%0d done=%0b err=%0b exp 4/0/1/0", pass_cnt, fail_cnt, done, err); end
  endtask

  // LATENCY=3 checker: restart from DONE while two predictions are in flight
  task automatic test_flush();
    do_reset();
    pulse_start(16'd2);
    for (int i = 0; i < 4; i++) begin
      a = va[i + 4]; b = vb[i + 4]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (done3 !== 1'b1 || pass3 !== 16'd2) begin n_errors++; $display("FAIL flush_first_run done=%0b pass=%0d exp 1/2", done3, pass3); end
    pulse_start(16'd2);
    n_checks++; if (busy3 !== 1'b1 || pass3 !== 16'd0) begin n_errors++; $display("FAIL flush_restart busy=%0b pass=%0d exp 1/0", busy3, pass3); end
    tick();
    n_checks++; if (pass3 !== 16'd0 || fail3 !== 16'd0) begin n_errors++; $display("FAIL flush_stale1 got=%0d/%0d exp=0/0", pass3, fail3); end
    tick();
    n_checks++; if (pass3 !== 16'd0 || fail3 !== 16'd0 || busy3 !== 1'b1) begin n_errors++; $display("FAIL flush_stale2 got=%0d/%0d busy=%0b exp=0/0/1", pass3, fail3, busy3); end
    for (int i = 0; i < 2; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (pass3 !== 16'd1 || done3 !== 1'b0) begin n_errors++; $display("FAIL flush_mid pass=%0d done=%0b exp 1/0", pass3, done3); end
    tick();
    n_checks++; if (pass3 !== 16'd2 || fail3 !== 16'd0 || done3 !== 1'b1) begin n_errors++; $display("FAIL flush_end pass=%0d fail=%0d done=%0b exp 2/0/1", pass3, fail3, done3); end
  endtask

  task automatic test_halt();
    do_reset();
    pulse_start(16'd8);
    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1; corrupt = (i == 3);
      tick();
      if (i == 3) begin
        n_checks++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd1 || done !== (HALT != 0)) begin n_errors++; $display("FAIL halt_at_fail pass=%0d fail=%0d done=%0b exp 2/1/%0d", pass_cnt, fail_cnt, done, HALT); end
      end
    end
    in_valid = 1'b0; corrupt = 1'b0;
    tick();
    n_checks++; if (pass_cnt !== ((HALT != 0) ? 16'd2 : 16'd7) || fail_cnt !== 16'd1 || done !== 1'b1) begin n_errors++; $display("FAIL halt_end pass=%0d fail=%0d done=%0b exp %0d/1/1", pass_cnt, fail_cnt, done, (HALT != 0) ? 2 : 7); end
    n_checks++; if (fail_a !== 16'h8000 || fail_b !== 16'h8000 || fail_c !== 17'h00000) begin n_errors++; $display("FAIL halt_capture got=%h/%h/%h exp=8000/8000/00000", fail_a, fail_b, fail_c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fail();
    test_gaps();
    test_zero_checks();
    test_mid_reset();
    test_flush();
    test_halt();
    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
